// File: rtl/dnaport_emu.sv
// Behavioural stand-in for the device-DNA serial port: loads a fixed ID on READ and shifts it out
// LSB-first on SHIFT, while tracking shift progress and flagging initiator protocol violations.
module dnaport_emu #(
  parameter logic [95:0] SIM_DNA = 96'h0,
  parameter int          WIDTH   = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read_i,
  input  logic       shift_i,
  input  logic       din_i,
  output logic       dout_o,
  output logic       loaded_o,
  output logic       done_o,
  output logic [7:0] shift_count_o,
  output logic       protocol_err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] WIDTH_C = 8'(WIDTH);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Handshake: none. read_i/shift_i are level commands sampled on every rising edge;
  // read_i wins over shift_i, and both low is an idle cycle that holds all state.

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [7:0]         count_q, count_d;
  logic               err_q, err_d;
  logic               do_shift;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    count_d  = count_q;
    err_d    = err_q;
    do_shift = shift_i && !read_i;

    if (read_i) begin
      sreg_d  = SIM_DNA[WIDTH-1:0];
      count_d = 8'd0;
      state_d = ST_READY;
      if (shift_i) begin
        err_d = 1'b1;
      end
    end else if (do_shift) begin
      sreg_d = {din_i, sreg_q[WIDTH-1:1]};
      if (count_q != CNT_MAX) begin
        count_d = count_q + 8'd1;
      end
      // Shifting an unloaded register is legal for the data path but a protocol error.
      case (state_q)
        ST_EMPTY: err_d = 1'b1;
        ST_READY: if (count_q + 8'd1 == WIDTH_C) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      sreg_q  <= '0;
      count_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign dout_o         = sreg_q[0];
  assign loaded_o       = (state_q != ST_EMPTY);
  assign done_o         = (state_q == ST_DONE);
  assign shift_count_o  = count_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_dnaport_emu.sv
// Directed bench for dnaport_emu: a driver issues one command per cycle and queues the expected
// outputs; a monitor compares them once the command has been sampled.
module tb_dnaport_emu;

  localparam logic [95:0] DNA_C = 96'h112233445566778899AABBCC;
  localparam int          W     = 44;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read_i = 1'b0;
  logic       shift_i = 1'b0;
  logic       din_i = 1'b0;
  logic       dout_o;
  logic       loaded_o;
  logic       done_o;
  logic [7:0] shift_count_o;
  logic       protocol_err_o;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [95:0] dna = DNA_C;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  dnaport_emu #(.SIM_DNA(DNA_C), .WIDTH(96)) dut (
    .clk(clk),
    .rst(rst),
    .read_i(read_i),
    .shift_i(shift_i),
    .din_i(din_i),
    .dout_o(dout_o),
    .loaded_o(loaded_o),
    .done_o(done_o),
    .shift_count_o(shift_count_o),
    .protocol_err_o(protocol_err_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp_v);
    end
  endtask

  // monitor: entry layout {due_cycle[31:0], dout, loaded, done, count[7:0], err}
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][43:12] == cyc) begin
      e = exp_q.pop_front();
      check1("dout",   {7'd0, dout_o},         {7'd0, e[11]});
      check1("loaded", {7'd0, loaded_o},       {7'd0, e[10]});
      check1("done",   {7'd0, done_o},         {7'd0, e[9]});
      check1("count",  shift_count_o,          e[8:1]);
      check1("err",    {7'd0, protocol_err_o}, {7'd0, e[0]});
    end
  end

  // driver: apply one command for one cycle and queue the expected post-edge outputs
  task automatic cmd(input logic r, input logic rd, input logic sh, input logic di,
                     input logic e_dout, input logic e_ld, input logic e_dn,
                     input logic [7:0] e_cnt, input logic e_err);
    @(posedge clk);
    #1;
    rst = r; read_i = rd; shift_i = sh; din_i = di;
    exp_q.push_back({32'(cyc + 1), e_dout, e_ld, e_dn, e_cnt, e_err});
  endtask

  initial begin
    // reset for 10 cycles, then an idle cycle
    for (int i = 0; i < 10; i++) cmd(1, 0, 0, 0, 0, 0, 0, 8'd0, 0);
    cmd(0, 0, 0, 0, 0, 0, 0, 8'd0, 0);

    // READ, 95 shifts with din=0: dout walks SIM_DNA LSB-first
    cmd(0, 1, 0, 0, dna[0], 1, 0, 8'd0, 0);
    for (int k = 1; k <= 95; k++) cmd(0, 0, 1, 0, dna[k], 1, 0, 8'(k), 0);
    // 96th shift completes; the register now holds only shifted-in zeros
    cmd(0, 0, 1, 0, 0, 1, 1, 8'd96, 0);
    for (int k = 97; k <= 100; k++) cmd(0, 0, 1, 1, 0, 1, 1, 8'(k), 0);
    // idle holds state
    cmd(0, 0, 0, 0, 0, 1, 1, 8'd100, 0);
    cmd(0, 0, 0, 0, 0, 1, 1, 8'd100, 0);

    // READ again, then loopback dout->din: the ID recirculates, count saturates at 255
    cmd(0, 1, 0, 0, dna[0], 1, 0, 8'd0, 0);
    for (int k = 1; k <= 270; k++) begin
      cmd(0, 0, 1, dna[(k - 1) % 96], dna[k % 96], 1, (k >= 96), (k > 255) ? 8'd255 : 8'(k), 0);
    end
    cmd(0, 0, 0, 0, dna[270 % 96], 1, 1, 8'd255, 0);

    // reset, then SHIFT before any READ
    cmd(1, 0, 0, 0, 0, 0, 0, 8'd0, 0);
    cmd(0, 0, 1, 1, 0, 0, 0, 8'd1, 1);
    cmd(0, 0, 0, 0, 0, 0, 0, 8'd1, 1);
    // READ+SHIFT together: load wins, no shift, error stays set
    cmd(0, 1, 1, 1, dna[0], 1, 0, 8'd0, 1);
    cmd(0, 0, 1, 0, dna[1], 1, 0, 8'd1, 1);
    cmd(0, 0, 1, 0, dna[2], 1, 0, 8'd2, 1);

    // reset mid-shift clears everything, including the sticky error
    cmd(1, 0, 1, 1, 0, 0, 0, 8'd0, 0);
    cmd(0, 1, 0, 0, dna[0], 1, 0, 8'd0, 0);
    cmd(0, 0, 1, 0, dna[1], 1, 0, 8'd1, 0);
    // READ+SHIFT from READY is on its own a protocol error
    cmd(0, 1, 1, 0, dna[0], 1, 0, 8'd0, 1);
    // rst overrides a simultaneous READ
    cmd(1, 1, 0, 0, 0, 0, 0, 8'd0, 0);
    cmd(0, 0, 0, 0, 0, 0, 0, 8'd0, 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
